// File: rtl/hub75_stream_writer_pkg.sv
// hub75_stream_writer_pkg: shared state encoding for the HUB75 stream writer
package hub75_stream_writer_pkg;
  typedef enum logic [2:0] {IDLE, FILL, SWAP_WAIT, SWAP, STORE, FSWAP_WAIT, FSWAP} state_t;
endpackage

// File: rtl/hub75_stream_writer.sv
// hub75_stream_writer: raster pixel stream to HUB75 frame buffer row writes, row swap/store and frame swap
module hub75_stream_writer
  import hub75_stream_writer_pkg::*;
#(
  parameter int N_BANKS = 2,
  parameter int N_ROWS = 32,
  parameter int N_COLS = 64,
  parameter int N_CHANS = 3,
  parameter int N_PLANES = 8,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_CHANS*N_PLANES-1:0] in_data,
  input  logic in_sof,
  input  logic in_valid,
  output logic in_ready,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0] wr_row_addr,
  output logic wr_row_store,
  input  logic wr_row_rdy,
  output logic wr_row_swap,
  output logic [N_CHANS*N_PLANES-1:0] wr_data,
  output logic [LOG_N_COLS-1:0] wr_col_addr,
  output logic wr_en,
  output logic frame_swap,
  output logic err_sync
);
  localparam logic [LOG_N_COLS-1:0] X_LAST = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0] ROW_LAST = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_BANKS-1:0] BANK_LAST = LOG_N_BANKS'(N_BANKS - 1);
  state_t state, state_nxt;
  logic [LOG_N_COLS-1:0] x, col;
  logic [LOG_N_ROWS-1:0] row;
  logic [LOG_N_BANKS-1:0] bank;
  logic acc, wr_pix, last_col, last_line, at_origin, err_set;
  assign in_ready = state == IDLE || state == FILL;
  assign acc = in_valid & in_ready;
  assign wr_pix = acc & (state == FILL | in_sof);
  assign col = in_sof ? '0 : x;
  assign last_col = col == X_LAST;
  assign last_line = bank == BANK_LAST && row == ROW_LAST;
  assign at_origin = x == '0 && row == '0 && bank == '0;
  assign err_set = acc & (state == IDLE ? !in_sof : in_sof & !at_origin);
  assign wr_row_swap = state == SWAP;
  assign wr_row_store = state == STORE;
  assign frame_swap = state == FSWAP && wr_row_rdy;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FILL: if (wr_pix) state_nxt = last_col ? SWAP_WAIT : FILL;
      SWAP_WAIT: if (wr_row_rdy) state_nxt = SWAP;
      SWAP: state_nxt = STORE;
      STORE: state_nxt = last_line ? FSWAP_WAIT : FILL;
      FSWAP_WAIT: state_nxt = FSWAP;
      FSWAP: if (wr_row_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      row <= '0;
      bank <= '0;
      err_sync <= 1'b0;
      wr_bank_addr <= '0;
      wr_row_addr <= '0;
    end else begin
      err_sync <= err_sync | err_set;
      wr_bank_addr <= bank;
      wr_row_addr <= row;
      if (wr_pix) begin
        x <= last_col ? '0 : col + 1'b1;
        if (in_sof) begin
          row <= '0;
          bank <= '0;
        end
      end else if (state == STORE && !last_line) begin
        x <= '0;
        row <= row == ROW_LAST ? '0 : row + 1'b1;
        if (row == ROW_LAST) bank <= bank + 1'b1;
      end else if (frame_swap) begin
        row <= '0;
        bank <= '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en <= 1'b0;
      wr_col_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_pix;
      if (wr_pix) begin
        wr_col_addr <= col;
        wr_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_hub75_stream_writer.sv
// tb_hub75_stream_writer: randomized self-checking bench against a frame-position reference model
module tb_hub75_stream_writer;
  localparam int NB = 2, NR = 4, NC = 8, NCH = 3, NP = 4, W = NCH * NP, NPIX = NB * NR * NC;
  logic clk = 0, rst = 1;
  logic [W-1:0] in_data = '0;
  logic in_sof = 0, in_valid = 0, in_ready;
  logic [0:0] wr_bank_addr;
  logic [1:0] wr_row_addr;
  logic wr_row_store, wr_row_rdy = 1, wr_row_swap;
  logic [W-1:0] wr_data;
  logic [2:0] wr_col_addr;
  logic wr_en, frame_swap, err_sync;
  int cyc = 0, checks = 0, errors = 0;
  int got_wr[$], got_st[$], st_cyc[$], sw_cyc[$], fs_cyc[$], acc_cyc[$];
  int exp_wr[$], exp_st[$];
  int exp_fs = 0, overlap = 0, p = -1;
  bit exp_err = 0;

  hub75_stream_writer #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .N_CHANS(NCH), .N_PLANES(NP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr), .wr_row_store(wr_row_store),
    .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap), .wr_data(wr_data), .wr_col_addr(wr_col_addr),
    .wr_en(wr_en), .frame_swap(frame_swap), .err_sync(err_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (wr_en) got_wr.push_back((int'(wr_col_addr) << 16) | int'(wr_data));
      if (wr_row_swap) begin
        sw_cyc.push_back(cyc);
        if (wr_en) overlap++;
      end
      if (wr_row_store) begin
        got_st.push_back(int'(wr_bank_addr) * NR + int'(wr_row_addr));
        st_cyc.push_back(cyc);
      end
      if (frame_swap) fs_cyc.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int d, input bit s);
    if (p < 0 && !s) begin
      exp_err = 1;
      return;
    end
    if (s) begin
      if (p > 0) exp_err = 1;
      p = 0;
    end
    exp_wr.push_back(((p % NC) << 16) | d);
    p++;
    if (p % NC == 0) exp_st.push_back(p / NC - 1);
    if (p == NPIX) begin
      exp_fs++;
      p = -1;
    end
  endfunction

  task automatic clear();
    got_wr.delete(); got_st.delete(); st_cyc.delete(); sw_cyc.delete(); fs_cyc.delete(); acc_cyc.delete();
    exp_wr.delete(); exp_st.delete();
    exp_fs = 0;
    overlap = 0;
  endtask

  task automatic send(input int d, input bit s, input int gap);
    bit ok = 0;
    int n = 0, c = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_data = W'(d);
    in_sof = s;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      c = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    in_sof = 1'($urandom);
    in_data = W'($urandom);
    check("accept", ok, 1);
    if (ok) begin
      model(d, s);
      acc_cyc.push_back(c);
    end
  endtask

  task automatic pixels(input int n, input bit first_sof, input int gapmax);
    for (int i = 0; i < n; i++) send(int'($urandom_range(0, (1 << W) - 1)), first_sof && i == 0, int'($urandom_range(0, gapmax)));
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) check({tag, "_wr"}, i < got_wr.size() ? got_wr[i] : -1, exp_wr[i]);
    check({tag, "_nst"}, got_st.size(), exp_st.size());
    for (int i = 0; i < exp_st.size(); i++) check({tag, "_st"}, i < got_st.size() ? got_st[i] : -1, exp_st[i]);
    check({tag, "_nswap"}, sw_cyc.size(), exp_st.size());
    check({tag, "_fswap"}, fs_cyc.size(), exp_fs);
    check({tag, "_err"}, err_sync, exp_err);
    check({tag, "_overlap"}, overlap, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_swap"}, wr_row_swap, 0);
    check({tag, "_store"}, wr_row_store, 0);
    check({tag, "_fswap"}, frame_swap, 0);
    check({tag, "_err"}, err_sync, 0);
    check({tag, "_addr"}, {wr_bank_addr, wr_row_addr, wr_col_addr}, 0);
    check({tag, "_data"}, wr_data, 0);
  endtask

  initial begin
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;

    clear();
    pixels(NPIX, 1, 0);
    settle();
    compare("full");
    check("row_swap_lat", sw_cyc.size() > 0 ? sw_cyc[0] : -1, acc_cyc[NC-1] + 2);
    check("row_store_lat", st_cyc.size() > 0 ? st_cyc[0] : -1, acc_cyc[NC-1] + 3);
    check("ready_again", acc_cyc[NC], acc_cyc[NC-1] + 4);
    check("fswap_lat", fs_cyc.size() > 0 ? fs_cyc[0] : -1, st_cyc.size() == NB * NR ? st_cyc[NB*NR-1] + 2 : -2);

    clear();
    wr_row_rdy = 0;
    pixels(NC, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    wr_row_rdy = 1;
    check("stall_swap_early", sw_cyc.size(), 0);
    pixels(NPIX - NC, 0, 0);
    settle();
    compare("stall");
    check("stall_swap_lat", sw_cyc.size() > 0 ? sw_cyc[0] : -1, acc_cyc[NC-1] + 7);

    clear();
    pixels(3, 0, 3);
    settle();
    check("drop_nwr", got_wr.size(), 0);
    check("drop_err", err_sync, 1);
    pixels(NPIX, 1, 3);
    settle();
    compare("after_drop");

    clear();
    pixels(2 * NC + 5, 1, 2);
    pixels(NPIX, 1, 2);
    settle();
    compare("sof_mid");
    check("sof_mid_restart_store", got_st.size() > 2 ? got_st[2] : -1, 0);
    check("sof_mid_restart_col", got_wr.size() > 2 * NC + 5 ? got_wr[2*NC+5] >> 16 : -1, 0);

    clear();
    wr_row_rdy = 0;
    pixels(NC, 1, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    rst = 0;
    p = -1;
    exp_err = 0;
    clear();
    wr_row_rdy = 1;
    pixels(NPIX, 1, 1);
    settle();
    compare("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
